// File: rtl/bus_rr_pkg.sv
// Shared types for the round-robin multi-host interconnect: index widths
// and the response-tracking record captured at grant time.
package bus_rr_pkg;

  localparam int MaxPorts = 16;
  localparam int TrkIdxW  = $clog2(MaxPorts);

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [TrkIdxW-1:0] host;
    logic [TrkIdxW-1:0] dev;
    logic               derr;
  } trk_t;

endpackage

// File: rtl/bus_rr_if.sv
// Host-side and device-side bus bundle of bus_rr. The interconnect uses the
// slave modport; hosts, devices and configuration sit on the master side.
interface bus_rr_if #(
  parameter int NrHosts      = 2,
  parameter int NrDevices    = 3,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  localparam int BeWidth = DataWidth / 8;

  logic [NrHosts-1:0]      host_req_i;
  logic [NrHosts-1:0]      host_gnt_o;
  logic [AddressWidth-1:0] host_addr_i  [NrHosts];
  logic [NrHosts-1:0]      host_we_i;
  logic [BeWidth-1:0]      host_be_i    [NrHosts];
  logic [DataWidth-1:0]    host_wdata_i [NrHosts];
  logic [NrHosts-1:0]      host_rvalid_o;
  logic [DataWidth-1:0]    host_rdata_o [NrHosts];
  logic [NrHosts-1:0]      host_err_o;

  logic [NrDevices-1:0]    device_req_o;
  logic [AddressWidth-1:0] device_addr_o  [NrDevices];
  logic [NrDevices-1:0]    device_we_o;
  logic [BeWidth-1:0]      device_be_o    [NrDevices];
  logic [DataWidth-1:0]    device_wdata_o [NrDevices];
  logic [NrDevices-1:0]    device_rvalid_i;
  logic [DataWidth-1:0]    device_rdata_i [NrDevices];
  logic [NrDevices-1:0]    device_err_i;

  logic [AddressWidth-1:0] cfg_device_addr_base_i [NrDevices];
  logic [AddressWidth-1:0] cfg_device_addr_mask_i [NrDevices];

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    input  device_rvalid_i, device_rdata_i, device_err_i,
    input  cfg_device_addr_base_i, cfg_device_addr_mask_i
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    output device_rvalid_i, device_rdata_i, device_err_i,
    output cfg_device_addr_base_i, cfg_device_addr_mask_i
  );

endinterface

// File: rtl/bus_rr_arb.sv
// Round-robin arbiter: searches the request vector starting at the pointer,
// grants the first requester and moves the pointer just past it.
module bus_rr_arb
  import bus_rr_pkg::*;
#(
  parameter  int NrReq = 2,
  localparam int IdxW  = idx_width(NrReq)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NrReq-1:0] i_req,
  output logic [NrReq-1:0] o_gnt,
  output logic [IdxW-1:0]  o_idx,
  output logic             o_valid
);

  logic [IdxW-1:0]  r_ptr;
  logic [IdxW:0]    w_pos;
  logic [NrReq-1:0] w_shift;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    w_shift = '0;
    for (int k = 0; k < NrReq; k++) begin
      // candidate = (ptr + k) mod NrReq, kept one bit wider to avoid wrap
      w_pos = {1'b0, r_ptr} + (IdxW+1)'(k);
      if (w_pos >= (IdxW+1)'(NrReq)) begin
        w_pos = w_pos - (IdxW+1)'(NrReq);
      end
      w_shift = i_req >> w_pos;
      if (!o_valid && w_shift[0]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[IdxW-1:0];
      end
    end
    o_gnt = o_valid ? (NrReq'(1) << o_idx) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (o_idx == IdxW'(NrReq - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/bus_rr.sv
// Multi-host interconnect: round-robin grant, address decode onto devices,
// and a one-entry tracker that routes the next-cycle response to the host.
module bus_rr
  import bus_rr_pkg::*;
#(
  parameter int NrHosts      = 2,
  parameter int NrDevices    = 3,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input logic     clk_i,
  input logic     rst_ni,
  bus_rr_if.slave bus
);

  localparam int HostIdxW = idx_width(NrHosts);
  localparam int DevIdxW  = idx_width(NrDevices);
  localparam int BeWidth  = DataWidth / 8;

  logic [NrHosts-1:0]      w_gnt;
  logic [HostIdxW-1:0]     w_gnt_idx;
  logic                    w_gnt_valid;
  logic [AddressWidth-1:0] w_addr;
  logic                    w_we;
  logic [BeWidth-1:0]      w_be;
  logic [DataWidth-1:0]    w_wdata;
  logic [NrDevices-1:0]    w_match;
  logic                    w_hit;
  logic [DevIdxW-1:0]      w_dev_idx;
  logic                    w_dev_rvalid;
  logic [DataWidth-1:0]    w_dev_rdata;
  logic                    w_dev_err;
  trk_t                    r_trk;

  bus_rr_arb #(.NrReq(NrHosts)) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_req   (bus.host_req_i),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  assign bus.host_gnt_o = w_gnt;

  always_comb begin
    w_addr  = bus.host_addr_i[0];
    w_we    = bus.host_we_i[0];
    w_be    = bus.host_be_i[0];
    w_wdata = bus.host_wdata_i[0];
    for (int h = 1; h < NrHosts; h++) begin
      if (w_gnt_idx == HostIdxW'(h)) begin
        w_addr  = bus.host_addr_i[h];
        w_we    = bus.host_we_i[h];
        w_be    = bus.host_be_i[h];
        w_wdata = bus.host_wdata_i[h];
      end
    end
  end

  for (genvar gi = 0; gi < NrDevices; gi++) begin : g_match
    assign w_match[gi] =
      ((w_addr & bus.cfg_device_addr_mask_i[gi]) == bus.cfg_device_addr_base_i[gi]);
  end

  // Walk downwards so the lowest matching device is the one that sticks.
  always_comb begin
    w_hit     = 1'b0;
    w_dev_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if (w_match[d]) begin
        w_hit     = 1'b1;
        w_dev_idx = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    bus.device_req_o = '0;
    bus.device_we_o  = '0;
    for (int d = 0; d < NrDevices; d++) begin
      bus.device_req_o[d]   = w_gnt_valid && w_hit && (w_dev_idx == DevIdxW'(d));
      bus.device_addr_o[d]  = w_addr;
      bus.device_we_o[d]    = w_we;
      bus.device_be_o[d]    = w_be;
      bus.device_wdata_o[d] = w_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_trk <= '0;
    end else begin
      r_trk.valid <= w_gnt_valid;
      r_trk.host  <= TrkIdxW'(w_gnt_idx);
      r_trk.dev   <= TrkIdxW'(w_dev_idx);
      r_trk.derr  <= w_gnt_valid && !w_hit;
    end
  end

  always_comb begin
    w_dev_rvalid = 1'b0;
    w_dev_rdata  = '0;
    w_dev_err    = 1'b0;
    for (int d = 0; d < NrDevices; d++) begin
      if (r_trk.dev == TrkIdxW'(d)) begin
        w_dev_rvalid = bus.device_rvalid_i[d];
        w_dev_rdata  = bus.device_rdata_i[d];
        w_dev_err    = bus.device_err_i[d];
      end
    end
  end

  // A decode error answers on its own: rvalid forced, data zeroed.
  always_comb begin
    bus.host_rvalid_o = '0;
    bus.host_err_o    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      bus.host_rdata_o[h] = '0;
      if (r_trk.valid && (r_trk.host == TrkIdxW'(h))) begin
        bus.host_rvalid_o[h] = r_trk.derr | w_dev_rvalid;
        bus.host_rdata_o[h]  = r_trk.derr ? '0 : w_dev_rdata;
        bus.host_err_o[h]    = r_trk.derr | w_dev_err;
      end
    end
  end

  for (genvar gi = 0; gi < NrDevices; gi++) begin : g_resp_chk
    a_resp_tracked : assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.device_rvalid_i[gi] |-> (r_trk.valid && !r_trk.derr && (r_trk.dev == TrkIdxW'(gi))));
  end

endmodule

// File: tb/tb_bus_rr.sv
// Bench for bus_rr: directed scenarios with literal expectations plus a
// randomized phase compared every cycle against a rule-level model.
module tb_bus_rr;
  localparam int NH = 3;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_rr_if #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)) bus ();

  bus_rr #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Devices answer exactly one cycle after their request.
  logic [ND-1:0] dev_rv, dev_er, dev_err;
  logic [DW-1:0] dev_rd [ND];
  logic [DW-1:0] dev_data [ND];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dev_rv <= '0;
      dev_er <= '0;
      for (int d = 0; d < ND; d++) dev_rd[d] <= '0;
    end else begin
      dev_rv <= bus.device_req_o;
      dev_er <= dev_err & bus.device_req_o;
      for (int d = 0; d < ND; d++) dev_rd[d] <= dev_data[d];
    end
  end

  assign bus.device_rvalid_i = dev_rv;
  assign bus.device_err_i    = dev_er;
  assign bus.device_rdata_i  = dev_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pointer, one pending response.
  int            m_ptr = 0;
  bit            m_pv = 1'b0;
  int            m_ph = 0;
  logic [DW-1:0] m_prd = '0;
  bit            m_perr = 1'b0;

  always @(negedge clk) begin : cmp
    logic [NH-1:0] e_gnt, e_rv, e_err;
    logic [ND-1:0] e_req;
    int g, d;
    if (!rst_n) begin
      m_ptr = 0;
      m_pv  = 1'b0;
      chk("rst_rvalid", bus.host_rvalid_o, 0);
      chk("rst_err", bus.host_err_o, 0);
      for (int h = 0; h < NH; h++) chk("rst_rdata", bus.host_rdata_o[h], 0);
    end else begin
      e_rv  = '0;
      e_err = '0;
      if (m_pv) begin
        e_rv[m_ph]  = 1'b1;
        e_err[m_ph] = m_perr;
      end
      chk("rvalid", bus.host_rvalid_o, e_rv);
      chk("err", bus.host_err_o, e_err);
      for (int h = 0; h < NH; h++)
        chk("rdata", bus.host_rdata_o[h], (m_pv && m_ph == h) ? m_prd : '0);

      g = -1;
      for (int k = 0; k < NH; k++)
        if (g < 0 && bus.host_req_i[(m_ptr + k) % NH]) g = (m_ptr + k) % NH;
      e_gnt = '0;
      e_req = '0;
      m_pv  = 1'b0;
      if (g >= 0) begin
        e_gnt[g] = 1'b1;
        d = -1;
        for (int dd = ND - 1; dd >= 0; dd--)
          if ((bus.host_addr_i[g] & bus.cfg_device_addr_mask_i[dd]) == bus.cfg_device_addr_base_i[dd])
            d = dd;
        if (d >= 0) begin
          e_req[d] = 1'b1;
          chk("dev_addr", bus.device_addr_o[d], bus.host_addr_i[g]);
          chk("dev_we", bus.device_we_o[d], bus.host_we_i[g]);
          chk("dev_be", bus.device_be_o[d], bus.host_be_i[g]);
          chk("dev_wdata", bus.device_wdata_o[d], bus.host_wdata_i[g]);
          m_prd  = dev_data[d];
          m_perr = dev_err[d];
        end else begin
          m_prd  = '0;
          m_perr = 1'b1;
        end
        m_pv  = 1'b1;
        m_ph  = g;
        m_ptr = (g + 1) % NH;
        $display("txn t=%0t host=%0d addr=%h we=%0d dev=%0d", $time, g,
                 bus.host_addr_i[g], bus.host_we_i[g], d);
      end
      chk("gnt", bus.host_gnt_o, e_gnt);
      chk("dev_req", bus.device_req_o, e_req);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.host_req_i = '0;
  endtask

  task automatic req_host(input int h, input logic [AW-1:0] a, input logic we,
                          input logic [BW-1:0] be, input logic [DW-1:0] wd);
    bus.host_req_i[h]   = 1'b1;
    bus.host_addr_i[h]  = a;
    bus.host_we_i[h]    = we;
    bus.host_be_i[h]    = be;
    bus.host_wdata_i[h] = wd;
  endtask

  task automatic set_cfg(input bit overlap);
    bus.cfg_device_addr_base_i[0] = overlap ? 32'h0000_0000 : 32'h0010_0000;
    bus.cfg_device_addr_mask_i[0] = 32'hFFF0_0000;
    bus.cfg_device_addr_base_i[1] = 32'h0003_0000;
    bus.cfg_device_addr_mask_i[1] = 32'hFFFF_0000;
    bus.cfg_device_addr_base_i[2] = 32'h0002_0000;
    bus.cfg_device_addr_mask_i[2] = 32'hFFFF_0000;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       return 32'h0010_0000 | (r & 32'h000F_FFFF);
      1:       return 32'h0003_0000 | (r & 32'h0000_FFFF);
      2:       return 32'h0002_0000 | (r & 32'h0000_FFFF);
      3:       return 32'h0000_5000;
      default: return r;
    endcase
  endfunction

  initial begin : main
    logic [NH-1:0] g, alt;
    int cnt [NH];
    bus.host_req_i = '0;
    bus.host_we_i  = '0;
    for (int h = 0; h < NH; h++) begin
      bus.host_addr_i[h]  = '0;
      bus.host_be_i[h]    = '0;
      bus.host_wdata_i[h] = '0;
    end
    for (int d = 0; d < ND; d++) dev_data[d] = '0;
    dev_err = '0;
    set_cfg(1'b0);

    // Reset state
    @(negedge clk);
    chk("reset_gnt", bus.host_gnt_o, 0);
    chk("reset_dev_req", bus.device_req_o, 0);
    step();
    rst_n = 1'b1;

    // Host 0 reads RAM
    req_host(0, 32'h0010_0004, 1'b0, 4'hF, 32'h0);
    dev_data[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_gnt", bus.host_gnt_o, 3'b001);
    chk("t1_dev_req", bus.device_req_o, 3'b001);
    chk("t1_dev_addr", bus.device_addr_o[0], 32'h0010_0004);
    step();
    idle_all();
    @(negedge clk);
    chk("t1_rvalid", bus.host_rvalid_o, 3'b001);
    chk("t1_rdata", bus.host_rdata_o[0], 32'hDEAD_BEEF);
    chk("t1_err", bus.host_err_o, 3'b000);

    // Hosts 0 and 1 contend right after reset
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_host(0, 32'h0003_0000, 1'b0, 4'hF, 32'h0);
    req_host(1, 32'h0003_0040, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      alt = (i % 2 == 0) ? 3'b001 : 3'b010;
      chk("t2_gnt", bus.host_gnt_o, alt);
      if (i > 0) chk("t2_rvalid", bus.host_rvalid_o, (i % 2 == 0) ? 3'b010 : 3'b001);
      step();
    end
    idle_all();
    @(negedge clk);
    chk("t2_last_rvalid", bus.host_rvalid_o, 3'b010);

    // Host 1 writes an unmapped address
    step();
    req_host(1, 32'h0000_5000, 1'b1, 4'hF, 32'hCAFE_0001);
    @(negedge clk);
    chk("t3_gnt", bus.host_gnt_o, 3'b010);
    chk("t3_dev_req", bus.device_req_o, 3'b000);
    step();
    idle_all();
    @(negedge clk);
    chk("t3_rvalid", bus.host_rvalid_o, 3'b010);
    chk("t3_err", bus.host_err_o, 3'b010);
    chk("t3_rdata", bus.host_rdata_o[1], 32'h0);

    // Overlapping windows: lowest device wins
    step();
    set_cfg(1'b1);
    req_host(2, 32'h0002_0000, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t4_gnt", bus.host_gnt_o, 3'b100);
    chk("t4_dev_req", bus.device_req_o, 3'b001);
    step();
    idle_all();
    set_cfg(1'b0);
    @(negedge clk);
    chk("t4_rvalid", bus.host_rvalid_o, 3'b100);

    // Timer returns an error to host 0 only
    step();
    dev_data[2] = 32'h0000_1234;
    dev_err = 3'b100;
    req_host(0, 32'h0002_0010, 1'b0, 4'hF, 32'h0);
    req_host(1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t5_gnt", bus.host_gnt_o, 3'b001);
    chk("t5_dev_req", bus.device_req_o, 3'b100);
    step();
    bus.host_req_i[0] = 1'b0;
    dev_data[0] = 32'h5555_AAAA;
    @(negedge clk);
    chk("t5_rvalid", bus.host_rvalid_o, 3'b001);
    chk("t5_err", bus.host_err_o, 3'b001);
    chk("t5_rdata", bus.host_rdata_o[0], 32'h0000_1234);
    chk("t5_gnt_next", bus.host_gnt_o, 3'b010);
    step();
    idle_all();
    dev_err = '0;
    @(negedge clk);
    chk("t5_next_err", bus.host_err_o, 3'b000);
    chk("t5_next_rdata", bus.host_rdata_o[1], 32'h5555_AAAA);

    // Reset in the cycle after a grant drops the response and the pointer
    step();
    req_host(1, 32'h0003_0004, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t6_gnt", bus.host_gnt_o, 3'b010);
    step();
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_dropped", bus.host_rvalid_o, 3'b000);
    step();
    rst_n = 1'b1;
    req_host(0, 32'h0003_0008, 1'b0, 4'hF, 32'h0);
    req_host(2, 32'h0003_000C, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t6_gnt_after_rst", bus.host_gnt_o, 3'b001);
    chk("t6_no_rvalid", bus.host_rvalid_o, 3'b000);
    step();
    idle_all();
    @(negedge clk);

    // All hosts contend: each served once per NH cycles
    step();
    for (int h = 0; h < NH; h++) begin
      cnt[h] = 0;
      req_host(h, 32'h0010_0100 + 32'(h * 4), 1'b1, 4'h3, 32'(h));
    end
    for (int i = 0; i < 2 * NH; i++) begin
      @(negedge clk);
      for (int h = 0; h < NH; h++) cnt[h] += int'(bus.host_gnt_o[h]);
      step();
    end
    idle_all();
    for (int h = 0; h < NH; h++) chk("t7_fair_count", 64'(cnt[h]), 64'd2);

    // Randomized traffic with one reset in the middle
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      g = bus.host_gnt_o;
      step();
      if (c == 700) begin
        idle_all();
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
        for (int h = 0; h < NH; h++) begin
          if (bus.host_req_i[h] && !g[h]) continue;
          if ($urandom_range(0, 99) < 60)
            req_host(h, rand_addr(), 1'($urandom), 4'($urandom), $urandom);
          else
            bus.host_req_i[h] = 1'b0;
        end
      end
      for (int d = 0; d < ND; d++) dev_data[d] = $urandom;
      for (int d = 0; d < ND; d++) dev_err[d] = ($urandom_range(0, 9) == 0);
    end
    step();
    idle_all();
    @(negedge clk);
    step();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
